// File: rtl/jb_oran_spoof_pkg.sv
// Shared state encoding and default timing constants for the ORAN datapath reset sequencer.
package jb_oran_spoof_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StQuiesce,
        StReset,
        StSettle,
        StDone
    } seq_state_e;

    localparam int unsigned DefRstCycles    = 16;
    localparam int unsigned DefSettleCycles = 32;
    localparam int unsigned DefAckTimeout   = 255;
    localparam int unsigned DefCntW         = 16;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module jb_sat_counter
    import jb_oran_spoof_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] q_o
);

    logic [CNT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jb_oran_spoof_reset_seq.sv
// Timed datapath reset sequencer: quiesce request, ack wait with watchdog, reset hold, settle.
module jb_oran_spoof_reset_seq
    import jb_oran_spoof_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned ACK_TIMEOUT   = DefAckTimeout,
    parameter int unsigned CNT_W         = DefCntW
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             trig_in,
    input  logic             enable,
    input  logic             clear_status,
    input  logic             quiesce_ack,
    output logic             quiesce_req,
    output logic             dp_reset,
    output logic             busy,
    output logic             done,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] seq_count,
    output logic [CNT_W-1:0] overrun_count
);

    localparam int unsigned CntW = $clog2(max3(RST_CYCLES, SETTLE_CYCLES, ACK_TIMEOUT)) + 1;

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            quiesce_req_q, dp_reset_q, busy_q, done_q, timeout_q;
    logic            timeout_set, timeout_d, seq_inc, overrun_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        seq_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig_in && enable) begin
                    state_d = StQuiesce;
                    cnt_d   = CntW'(ACK_TIMEOUT - 1);
                end
            end
            StQuiesce: begin
                // An ack on the final watchdog cycle still counts as an ack.
                if (quiesce_ack) begin
                    state_d = StReset;
                    cnt_d   = CntW'(RST_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d     = StReset;
                    cnt_d       = CntW'(RST_CYCLES - 1);
                    timeout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StReset: begin
                if (cnt_q == '0) begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                seq_inc = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign timeout_d   = clear_status ? 1'b0 : (timeout_set ? 1'b1 : timeout_q);
    assign overrun_inc = trig_in && busy_q;

    // Outputs are flopped from next state so they line up with the state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            quiesce_req_q <= 1'b0;
            dp_reset_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            quiesce_req_q <= (state_d == StQuiesce) || (state_d == StReset) ||
                             (state_d == StSettle);
            dp_reset_q    <= (state_d == StReset);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
            timeout_q     <= timeout_d;
        end
    end

    jb_sat_counter #(
        .CNT_W (CNT_W)
    ) u_seq_cnt (
        .clk_i (aclk),
        .rst_i (areset),
        .inc_i (seq_inc),
        .clr_i (clear_status),
        .q_o   (seq_count)
    );

    jb_sat_counter #(
        .CNT_W (CNT_W)
    ) u_overrun_cnt (
        .clk_i (aclk),
        .rst_i (areset),
        .inc_i (overrun_inc),
        .clr_i (clear_status),
        .q_o   (overrun_count)
    );

    assign quiesce_req  = quiesce_req_q;
    assign dp_reset     = dp_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_jb_oran_spoof_reset_seq.sv
// Bench for the reset sequencer: directed table at default timing, small-parameter corners, random.
module tb_jb_oran_spoof_reset_seq;

    localparam int unsigned SR = 3;
    localparam int unsigned SS = 2;
    localparam int unsigned SA = 4;
    localparam int unsigned SW = 2;
    localparam int NR     = 600;
    localparam int SatMax = (1 << SW) - 1;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        arst0, trig0, en0, clr0, ack0;
    logic        qr0, dr0, busy0, done0, to0;
    logic [15:0] seq0, ovr0;

    logic          arst1, trig1, en1, clr1, ack1;
    logic          qr1, dr1, busy1, done1, to1;
    logic [SW-1:0] seq1, ovr1;

    jb_oran_spoof_reset_seq dut0 (
        .aclk          (aclk),
        .areset        (arst0),
        .trig_in       (trig0),
        .enable        (en0),
        .clear_status  (clr0),
        .quiesce_ack   (ack0),
        .quiesce_req   (qr0),
        .dp_reset      (dr0),
        .busy          (busy0),
        .done          (done0),
        .timeout_flag  (to0),
        .seq_count     (seq0),
        .overrun_count (ovr0)
    );

    jb_oran_spoof_reset_seq #(
        .RST_CYCLES    (SR),
        .SETTLE_CYCLES (SS),
        .ACK_TIMEOUT   (SA),
        .CNT_W         (SW)
    ) dut1 (
        .aclk          (aclk),
        .areset        (arst1),
        .trig_in       (trig1),
        .enable        (en1),
        .clear_status  (clr1),
        .quiesce_ack   (ack1),
        .quiesce_req   (qr1),
        .dp_reset      (dr1),
        .busy          (busy1),
        .done          (done1),
        .timeout_flag  (to1),
        .seq_count     (seq1),
        .overrun_count (ovr1)
    );

    typedef struct {
        int ack_at;
        int rst_first;
        int rst_last;
        int done_at;
        bit to;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   failures = 0;

    // Random-run stimulus and expected traces.
    logic r_trig[NR], r_en[NR], r_ack[NR], r_clr[NR];
    logic e_q[NR+1], e_r[NR+1], e_b[NR+1], e_d[NR+1], e_to[NR+1];
    logic t_set[NR+1], d_set[NR+1];
    int   e_seq[NR+1], e_ovr[NR+1];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        int q_first, q_last, r_first, r_last, d_at, d_cnt, d_first, free;
        bit any_busy;

        arst0 = 1'b1; trig0 = 1'b0; en0 = 1'b1; clr0 = 1'b0; ack0 = 1'b0;
        arst1 = 1'b1; trig1 = 1'b0; en1 = 1'b1; clr1 = 1'b0; ack1 = 1'b0;

        // ack cycle (-1 = never), dp_reset first/last cycle, done cycle, timeout expected
        vecs[0] = '{3, 4, 19, 52, 1'b0};
        vecs[1] = '{1, 2, 17, 50, 1'b0};
        vecs[2] = '{-1, 256, 271, 304, 1'b1};
        vecs[3] = '{255, 256, 271, 304, 1'b0};
        vecs[4] = '{0, 256, 271, 304, 1'b1};

        tick();
        tick();
        chk("reset_outputs", 32'({qr0, dr0, busy0, done0, to0}), 32'd0);
        chk("reset_counters", {seq0, ovr0}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            q_first = -1; q_last = -1; r_first = -1; r_last = -1; d_at = -1; d_cnt = 0;
            arst0 = 1'b1;
            tick();
            arst0 = 1'b0;
            for (int c = 0; c <= vecs[v].done_at + 2; c++) begin
                trig0 = (c == 0);
                ack0  = (c == vecs[v].ack_at);
                if (qr0) begin
                    if (q_first < 0) q_first = c;
                    q_last = c;
                end
                if (dr0) begin
                    if (r_first < 0) r_first = c;
                    r_last = c;
                end
                if (done0) begin
                    d_at = c;
                    d_cnt++;
                end
                tick();
            end
            trig0 = 1'b0;
            ack0  = 1'b0;
            chk($sformatf("vec%0d_qreq_first", v), q_first, 32'd1);
            chk($sformatf("vec%0d_qreq_last", v), q_last, vecs[v].done_at - 1);
            chk($sformatf("vec%0d_rst_first", v), r_first, vecs[v].rst_first);
            chk($sformatf("vec%0d_rst_last", v), r_last, vecs[v].rst_last);
            chk($sformatf("vec%0d_done_at", v), d_at, vecs[v].done_at);
            chk($sformatf("vec%0d_done_cnt", v), d_cnt, 32'd1);
            chk($sformatf("vec%0d_timeout", v), 32'(to0), 32'(vecs[v].to));
            chk($sformatf("vec%0d_seq_count", v), 32'(seq0), 32'd1);
            chk($sformatf("vec%0d_busy_after", v), 32'(busy0), 32'd0);
        end

        // Three triggers during RESET are dropped and counted.
        arst0 = 1'b1;
        tick();
        arst0 = 1'b0;
        d_cnt = 0;
        for (int c = 0; c <= 56; c++) begin
            trig0 = (c == 0) || (c == 5) || (c == 8) || (c == 10);
            ack0  = (c == 3);
            if (done0) d_cnt++;
            tick();
        end
        trig0 = 1'b0; ack0 = 1'b0;
        chk("overrun_count", 32'(ovr0), 32'd3);
        chk("overrun_one_done", d_cnt, 32'd1);
        chk("overrun_seq_count", 32'(seq0), 32'd1);

        // Disabled triggers are ignored entirely.
        arst0 = 1'b1;
        tick();
        arst0 = 1'b0;
        en0 = 1'b0;
        any_busy = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            trig0 = (c < 5);
            if (busy0 || qr0) any_busy = 1'b1;
            tick();
        end
        trig0 = 1'b0; en0 = 1'b1;
        chk("disabled_busy", 32'(any_busy), 32'd0);
        chk("disabled_counters", {seq0, ovr0}, 32'd0);

        // areset mid-RESET aborts without done; a later trigger runs a full sequence.
        arst0 = 1'b1;
        tick();
        arst0 = 1'b0;
        d_cnt = 0; d_at = -1;
        for (int c = 0; c <= 130; c++) begin
            trig0 = (c == 0) || (c == 61);
            ack0  = (c == 1) || (c == 63);
            arst0 = (c == 5);
            if (c == 4) chk("abort_pre_dp_reset", 32'(dr0), 32'd1);
            if (c == 6) chk("abort_outputs", 32'({dr0, qr0, busy0, done0}), 32'd0);
            if (done0) begin
                d_cnt++;
                d_at = c;
            end
            tick();
        end
        trig0 = 1'b0; ack0 = 1'b0; arst0 = 1'b0;
        chk("abort_done_cnt", d_cnt, 32'd1);
        chk("abort_rerun_done_at", d_at, 32'd112);
        chk("abort_rerun_seq", 32'(seq0), 32'd1);

        // clear_status on the DONE cycle wins over the increment and clears the flag.
        arst0 = 1'b1;
        tick();
        arst0 = 1'b0;
        for (int c = 0; c <= 310; c++) begin
            trig0 = (c == 0);
            clr0  = (c == 304);
            if (c == 300) chk("clr_flag_before", 32'(to0), 32'd1);
            if (c == 304) chk("clr_done_cycle", 32'(done0), 32'd1);
            tick();
        end
        trig0 = 1'b0; clr0 = 1'b0;
        chk("clr_seq_after", 32'(seq0), 32'd0);
        chk("clr_flag_after", 32'(to0), 32'd0);

        // Small-parameter instance: trigger on DONE is dropped, the next cycle is accepted.
        arst1 = 1'b1;
        tick();
        arst1 = 1'b0;
        d_cnt = 0; d_first = -1; d_at = -1;
        for (int c = 0; c <= 20; c++) begin
            trig1 = (c == 0) || (c == 7) || (c == 8);
            ack1  = (c == 1) || (c == 9);
            if (c == 8) chk("edge_idle_after_done", 32'(busy1), 32'd0);
            if (c == 9) begin
                chk("edge_busy_again", 32'(busy1), 32'd1);
                chk("edge_overrun_on_done", 32'(ovr1), 32'd1);
            end
            if (done1) begin
                if (d_first < 0) d_first = c;
                d_at = c;
                d_cnt++;
            end
            tick();
        end
        trig1 = 1'b0; ack1 = 1'b0;
        chk("edge_done_first", d_first, 32'd7);
        chk("edge_done_second", d_at, 32'd15);
        chk("edge_done_cnt", d_cnt, 32'd2);

        // Five sequences saturate a 2-bit counter at 3.
        arst1 = 1'b1;
        tick();
        arst1 = 1'b0;
        d_cnt = 0;
        for (int c = 0; c <= 59; c++) begin
            trig1 = ((c % 10) == 0) && (c < 50);
            ack1  = ((c % 10) == 1);
            if (done1) d_cnt++;
            tick();
        end
        trig1 = 1'b0; ack1 = 1'b0;
        chk("sat_done_cnt", d_cnt, 32'd5);
        chk("sat_seq_count", 32'(seq1), 32'd3);
        chk("sat_overrun", 32'(ovr1), 32'd0);

        // Random run against an interval-based schedule model.
        for (int c = 0; c < NR; c++) begin
            r_trig[c] = (c < NR - 30) && ($urandom_range(0, 99) < 18);
            r_en[c]   = ($urandom_range(0, 99) < 80);
            r_ack[c]  = ($urandom_range(0, 99) < 20);
            r_clr[c]  = ($urandom_range(0, 99) < 4);
        end
        for (int c = 0; c <= NR; c++) begin
            e_q[c] = 1'b0; e_r[c] = 1'b0; e_b[c] = 1'b0; e_d[c] = 1'b0;
            t_set[c] = 1'b0; d_set[c] = 1'b0;
        end
        free = 0;
        for (int s = 0; s < NR; s++) begin
            if (s >= free && r_trig[s] && r_en[s]) begin
                int k, d;
                bit tmo;
                k = -1;
                for (int j = s + 1; j <= s + int'(SA); j++) begin
                    if (k < 0 && r_ack[j]) k = j;
                end
                tmo = (k < 0);
                if (tmo) k = s + int'(SA);
                d = k + int'(SR) + int'(SS) + 1;
                for (int j = s + 1; j <= d; j++) begin
                    e_b[j] = 1'b1;
                    e_q[j] = (j < d);
                    e_r[j] = (j > k) && (j <= k + int'(SR));
                    e_d[j] = (j == d);
                end
                t_set[k] = tmo;
                d_set[d] = 1'b1;
                free = d + 1;
            end
        end
        e_seq[0] = 0; e_ovr[0] = 0; e_to[0] = 1'b0;
        for (int c = 0; c < NR; c++) begin
            int ns, no;
            ns = e_seq[c] + (d_set[c] ? 1 : 0);
            no = e_ovr[c] + ((r_trig[c] && e_b[c]) ? 1 : 0);
            e_seq[c+1] = r_clr[c] ? 0 : ((ns > SatMax) ? SatMax : ns);
            e_ovr[c+1] = r_clr[c] ? 0 : ((no > SatMax) ? SatMax : no);
            e_to[c+1]  = r_clr[c] ? 1'b0 : (t_set[c] ? 1'b1 : e_to[c]);
        end

        arst1 = 1'b1;
        tick();
        arst1 = 1'b0;
        for (int c = 0; c < NR; c++) begin
            trig1 = r_trig[c];
            en1   = r_en[c];
            ack1  = r_ack[c];
            clr1  = r_clr[c];
            chk($sformatf("rand_c%0d", c),
                32'({qr1, dr1, busy1, done1, to1, seq1, ovr1}),
                32'({e_q[c], e_r[c], e_b[c], e_d[c], e_to[c], 2'(e_seq[c]), 2'(e_ovr[c])}));
            tick();
        end
        trig1 = 1'b0; en1 = 1'b1; ack1 = 1'b0; clr1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
